// File: rtl/bicubic_pkg.sv
// Shared constants and helpers for the bicubic weight generator.
package bicubic_pkg;

    // Widest value the helpers below operate on; callers size-cast into it.
    localparam int MAX_W = 64;
    typedef logic signed [MAX_W-1:0] wide_t;

    // Signed width of the tap polynomial datapath, with headroom so no
    // intermediate term can wrap for any A or distance in range.
    function automatic int int_width(input int frac_w, input int a_w);
        return 4 * frac_w + a_w + 6;
    endfunction

    // Fixed-point 1.0 at the given fraction width.
    function automatic wide_t one_val(input int frac_w);
        return wide_t'(1) <<< frac_w;
    endfunction

    // Half an output LSB expressed at the polynomial scale (ONE^3).
    function automatic wide_t half_lsb(input int frac_w);
        return wide_t'(1) <<< (3 * frac_w - 1);
    endfunction

    // Clamp a signed value to the signed range of out_w bits.
    function automatic wide_t saturate(input wide_t v, input int out_w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/bicubic_kernel_tap.sv
// One kernel tap: distance D (scaled by ONE) and coefficient A in, rounded
// and saturated signed weight out. Three registered stages after the input.
module bicubic_kernel_tap
    import bicubic_pkg::*;
#(
    parameter int FRAC_W = 8,
    parameter int A_W    = 9,
    parameter int OUT_W  = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [FRAC_W+1:0]       d,
    input  logic [A_W-1:0]          a,
    input  logic                    mode,
    input  logic                    load,
    output logic signed [OUT_W-1:0] w,
    output logic                    sat
);

    localparam int W = int_width(FRAC_W, A_W);
    typedef logic signed [W-1:0] int_t;

    localparam int_t ONE_I  = int_t'(one_val(FRAC_W));
    localparam int_t ONE2   = ONE_I * ONE_I;
    localparam int_t ONE3   = ONE2 * ONE_I;
    localparam int_t ONE4   = ONE3 * ONE_I;
    localparam int_t TWO_1  = ONE_I + ONE_I;
    localparam int_t THREE1 = TWO_1 + ONE_I;
    localparam int_t HALF_I = int_t'(half_lsb(FRAC_W));
    localparam int_t K4     = int_t'(4);
    localparam int_t K5     = int_t'(5);
    localparam int_t K8     = int_t'(8);

    int_t  dw;
    int_t  aw;
    int_t  d_s2;
    int_t  d2_s2;
    int_t  d3_s2;
    int_t  a_s2;
    logic  mode_s2;
    int_t  p_next;
    int_t  p_s3;
    int_t  rounded;
    wide_t wide;
    wide_t clamped;

    assign dw = int_t'(d);
    assign aw = int_t'(a);

    // Stage 2: powers of the distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_s2    <= '0;
            d2_s2   <= '0;
            d3_s2   <= '0;
            a_s2    <= '0;
            mode_s2 <= 1'b0;
        end else if (en) begin
            d_s2    <= dw;
            d2_s2   <= dw * dw;
            d3_s2   <= dw * dw * dw;
            a_s2    <= aw;
            mode_s2 <= mode;
        end
    end

    // Piecewise polynomial at ONE^4 scale; bilinear is the tent (ONE-D)*ONE^3.
    always_comb begin
        p_next = '0;
        if (mode_s2) begin
            if (d_s2 <= ONE_I) p_next = (ONE_I - d_s2) * ONE3;
        end else if (d_s2 <= ONE_I) begin
            p_next = (TWO_1 - a_s2) * d3_s2 - (THREE1 - a_s2) * d2_s2 * ONE_I + ONE4;
        end else begin
            p_next = -(a_s2 * (d3_s2 - K5 * d2_s2 * ONE_I + K8 * d_s2 * ONE2 - K4 * ONE3));
        end
    end

    // Stage 3: register the polynomial value.
    always_ff @(posedge clk) begin
        if (rst) p_s3 <= '0;
        else if (en) p_s3 <= p_next;
    end

    // Round half up via arithmetic shift (signed floor), then clamp.
    always_comb begin
        rounded = (p_s3 + HALF_I) >>> (3 * FRAC_W);
        wide    = wide_t'(rounded);
        clamped = saturate(wide, OUT_W);
    end

    // Stage 4: output register, updated only for valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            w   <= '0;
            sat <= 1'b0;
        end else if (en && load) begin
            w   <= clamped[OUT_W-1:0];
            sat <= (clamped != wide);
        end
    end

endmodule

// File: rtl/bicubic_weight_gen.sv
// Four-tap bicubic/bilinear interpolation weight generator, 4-cycle pipeline.
module bicubic_weight_gen
    import bicubic_pkg::*;
#(
    parameter int FRAC_W    = 8,
    parameter int A_W       = 9,
    parameter int OUT_W     = 17,
    parameter int TAG_W     = 12,
    parameter int DEFAULT_A = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [FRAC_W-1:0]       in_t,
    input  logic                    in_mode,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    cfg_we,
    input  logic [A_W-1:0]          cfg_a,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_w0,
    output logic signed [OUT_W-1:0] out_w1,
    output logic signed [OUT_W-1:0] out_w2,
    output logic signed [OUT_W-1:0] out_w3,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_sat
);

    // Flow control: a sample is accepted on a clock edge where en and
    // in_valid are both high. There is no backpressure; en low freezes every
    // stage (data, valids, outputs), and out_valid marks the edge-aligned
    // result of one accepted sample, four enabled edges after its accept.

    localparam int DW = FRAC_W + 2;
    localparam logic [DW-1:0] ONE_D = DW'(1) << FRAC_W;

    logic [A_W-1:0]          a_reg;
    logic [DW-1:0]           t_ext;
    logic [DW-1:0]           d_s1 [4];
    logic [A_W-1:0]          a_s1;
    logic                    mode_s1;
    logic                    v1, v2, v3;
    logic [TAG_W-1:0]        tag1, tag2, tag3;
    logic signed [OUT_W-1:0] w_tap [4];
    logic [3:0]              sat_tap;

    assign t_ext = DW'(in_t);

    // Coefficient register: writes are independent of the pipeline enable.
    always_ff @(posedge clk) begin
        if (rst) a_reg <= A_W'(DEFAULT_A);
        else if (cfg_we) a_reg <= cfg_a;
    end

    // Stage 1: tap distances and the A in force at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            d_s1    <= '{default: '0};
            a_s1    <= '0;
            mode_s1 <= 1'b0;
            tag1    <= '0;
        end else if (en) begin
            v1      <= in_valid;
            d_s1[0] <= ONE_D + t_ext;
            d_s1[1] <= t_ext;
            d_s1[2] <= ONE_D - t_ext;
            d_s1[3] <= (ONE_D << 1) - t_ext;
            a_s1    <= a_reg;
            mode_s1 <= in_mode;
            tag1    <= in_tag;
        end
    end

    // Valid and tag sideband aligned with the tap stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            tag2      <= '0;
            tag3      <= '0;
            out_tag   <= '0;
        end else if (en) begin
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            tag2      <= tag1;
            tag3      <= tag2;
            if (v3) out_tag <= tag3;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_tap
        bicubic_kernel_tap #(
            .FRAC_W (FRAC_W),
            .A_W    (A_W),
            .OUT_W  (OUT_W)
        ) u_tap (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .d    (d_s1[i]),
            .a    (a_s1),
            .mode (mode_s1),
            .load (v3),
            .w    (w_tap[i]),
            .sat  (sat_tap[i])
        );
    end

    assign out_w0  = w_tap[0];
    assign out_w1  = w_tap[1];
    assign out_w2  = w_tap[2];
    assign out_w3  = w_tap[3];
    assign out_sat = |sat_tap;

endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Directed bench for bicubic_weight_gen with an expected-result queue.
module tb_bicubic_weight_gen;

    localparam int EW = 4 * 17 + 12 + 1;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, in_mode, cfg_we;
    logic        in_valid9, cfg_we9;
    logic [7:0]  in_t;
    logic [11:0] in_tag;
    logic [8:0]  cfg_a, cfg_a9;

    logic               out_valid, out_sat;
    logic signed [16:0] out_w0, out_w1, out_w2, out_w3;
    logic [11:0]        out_tag;

    logic              out9_valid, out9_sat;
    logic signed [8:0] out9_w0, out9_w1, out9_w2, out9_w3;
    logic [11:0]       out9_tag;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp9_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int a_model;
    bit ok;

    // Clock and DUTs
    always #5 clk = ~clk;

    bicubic_weight_gen dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_t(in_t),
        .in_mode(in_mode), .in_tag(in_tag), .cfg_we(cfg_we), .cfg_a(cfg_a),
        .out_valid(out_valid), .out_w0(out_w0), .out_w1(out_w1),
        .out_w2(out_w2), .out_w3(out_w3), .out_tag(out_tag), .out_sat(out_sat)
    );

    bicubic_weight_gen #(.OUT_W(9)) dut9 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid9), .in_t(in_t),
        .in_mode(in_mode), .in_tag(in_tag), .cfg_we(cfg_we9), .cfg_a(cfg_a9),
        .out_valid(out9_valid), .out_w0(out9_w0), .out_w1(out9_w1),
        .out_w2(out9_w2), .out_w3(out9_w3), .out_tag(out9_tag), .out_sat(out9_sat)
    );

    function automatic logic [EW-1:0] pack(input int w0, input int w1, input int w2,
                                           input int w3, input logic [11:0] tag,
                                           input logic sat);
        return {17'(w0), 17'(w1), 17'(w2), 17'(w3), tag, sat};
    endfunction

    // Reference tap value straight from the kernel definition (ONE = 256).
    function automatic longint tap_ref(input longint d, input longint a);
        longint one, p;
        one = 256;
        if (d <= one) p = (2*one - a)*d*d*d - (3*one - a)*d*d*one + one*one*one*one;
        else          p = -a * (d*d*d - 5*d*d*one + 8*d*one*one - 4*one*one*one);
        return (p + (longint'(1) <<< 23)) >>> 24;
    endfunction

    function automatic logic [EW-1:0] model(input int t, input bit mode,
                                            input logic [11:0] tag, input int a);
        longint w[4];
        logic s;
        if (mode) return pack(0, 256 - t, t, 0, tag, 1'b0);
        w[0] = tap_ref(256 + t, a);
        w[1] = tap_ref(t, a);
        w[2] = tap_ref(256 - t, a);
        w[3] = tap_ref(512 - t, a);
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w[i] > 65535)  begin w[i] = 65535;  s = 1'b1; end
            if (w[i] < -65536) begin w[i] = -65536; s = 1'b1; end
        end
        return pack(int'(w[0]), int'(w[1]), int'(w[2]), int'(w[3]), tag, s);
    endfunction

    task automatic cmp_pack(input string name, input logic [EW-1:0] got,
                            input logic [EW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got w=(%0d,%0d,%0d,%0d) tag=%h sat=%b, want w=(%0d,%0d,%0d,%0d) tag=%h sat=%b",
                     name, $signed(got[80:64]), $signed(got[63:47]), $signed(got[46:30]),
                     $signed(got[29:13]), got[12:1], got[0],
                     $signed(exp[80:64]), $signed(exp[63:47]), $signed(exp[46:30]),
                     $signed(exp[29:13]), exp[12:1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Driver: present one sample and hold it until an enabled edge accepts it.
    task automatic issue(input logic [7:0] t, input logic mode, input logic [11:0] tag,
                         input logic we, input logic [8:0] ca, input bit rand_en,
                         output bit acc);
        acc = 1'b0;
        in_valid = 1'b1; in_t = t; in_mode = mode; in_tag = tag;
        cfg_we = we; cfg_a = ca;
        for (int k = 0; k < 64 && !acc; k++) begin
            en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            acc = en;
            @(negedge clk);
            cfg_we = 1'b0;
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept: t=%0d not accepted within 64 cycles", t);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        en = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain;
        in_valid = 1'b0;
        in_valid9 = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 60 && (exp_q.size() != 0 || exp9_q.size() != 0); k++)
            @(negedge clk);
        check_val("drain_pending", exp_q.size() + exp9_q.size(), 0);
    endtask

    // Monitor: each enabled edge with out_valid high is one new result.
    initial begin
        bit adv;
        forever begin
            @(posedge clk);
            adv = en && !rst;
            #1;
            if (adv && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got out_valid=1 tag=%h, want no result", out_tag);
                end else begin
                    cmp_pack("result", pack(out_w0, out_w1, out_w2, out_w3, out_tag, out_sat),
                             exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit adv;
        forever begin
            @(posedge clk);
            adv = en && !rst;
            #1;
            if (adv && out9_valid) begin
                if (exp9_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result9: got out_valid=1 tag=%h, want no result", out9_tag);
                end else begin
                    cmp_pack("result9", pack(out9_w0, out9_w1, out9_w2, out9_w3, out9_tag, out9_sat),
                             exp9_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_t = '0; in_mode = 1'b0;
        in_tag = '0; cfg_we = 1'b0; cfg_a = '0;
        in_valid9 = 1'b0; cfg_we9 = 1'b0; cfg_a9 = '0;
        a_model = 128;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_w0", out_w0, 0);
        check_val("rst_out_w1", out_w1, 0);
        check_val("rst_out_w3", out_w3, 0);
        check_val("rst_out_tag", out_tag, 0);
        check_val("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        en = 1'b1;

        // t = 0 bicubic and exact 4-cycle latency
        exp_q.push_back(pack(0, 256, 0, 0, 12'h001, 1'b0));
        issue(8'd0, 1'b0, 12'h001, 1'b0, 9'd0, 1'b0, ok);
        in_valid = 1'b0;
        check_val("latency_edge1", out_valid, 0);
        @(negedge clk);
        check_val("latency_edge2", out_valid, 0);
        @(negedge clk);
        check_val("latency_edge3", out_valid, 0);
        @(negedge clk);
        check_val("latency_edge4", out_valid, 1);
        idle(3);

        // t = 0.5 with default A
        exp_q.push_back(pack(-16, 144, 144, -16, 12'h002, 1'b0));
        issue(8'd128, 1'b0, 12'h002, 1'b0, 9'd0, 1'b0, ok);

        // A write in the same cycle as a sample, then a sample with the new A
        exp_q.push_back(pack(-16, 144, 144, -16, 12'h003, 1'b0));
        issue(8'd128, 1'b0, 12'h003, 1'b1, 9'd192, 1'b0, ok);
        a_model = 192;
        exp_q.push_back(pack(-24, 152, 152, -24, 12'h004, 1'b0));
        issue(8'd128, 1'b0, 12'h004, 1'b0, 9'd0, 1'b0, ok);
        idle(6);

        // Bilinear with tag, then held outputs while idle
        exp_q.push_back(pack(0, 192, 64, 0, 12'h5A5, 1'b0));
        issue(8'd64, 1'b1, 12'h5A5, 1'b0, 9'd0, 1'b0, ok);
        idle(8);
        check_val("hold_out_valid", out_valid, 0);
        check_val("hold_out_w1", out_w1, 192);
        check_val("hold_out_w2", out_w2, 64);
        check_val("hold_out_tag", out_tag, 12'h5A5);

        // Stream of every phase with a random enable
        for (int t = 0; t < 256; t++) begin
            bit m;
            m = (t % 7 == 3);
            exp_q.push_back(model(t, m, 12'(t + 256), a_model));
            issue(8'(t), m, 12'(t + 256), 1'b0, 9'd0, 1'b1, ok);
        end
        drain();

        // Reset with three samples in flight
        issue(8'd10, 1'b0, 12'h0A1, 1'b0, 9'd0, 1'b0, ok);
        issue(8'd20, 1'b0, 12'h0A2, 1'b0, 9'd0, 1'b0, ok);
        issue(8'd30, 1'b0, 12'h0A3, 1'b0, 9'd0, 1'b0, ok);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_model = 128;
        idle(8);
        check_val("flush_out_valid", out_valid, 0);
        check_val("flush_out_w1", out_w1, 0);
        check_val("flush_out_tag", out_tag, 0);

        // A back at its reset value
        exp_q.push_back(pack(-16, 144, 144, -16, 12'h0B0, 1'b0));
        issue(8'd128, 1'b0, 12'h0B0, 1'b0, 9'd0, 1'b0, ok);
        drain();

        // Narrow output: A = 511, then t = 0 where w1 = 256 clamps to 255
        cfg_we9 = 1'b1;
        cfg_a9 = 9'd511;
        @(negedge clk);
        cfg_we9 = 1'b0;
        exp9_q.push_back(pack(-64, 192, 192, -64, 12'h009, 1'b0));
        exp9_q.push_back(pack(0, 255, 0, 0, 12'h00A, 1'b1));
        en = 1'b1;
        in_valid9 = 1'b1; in_mode = 1'b0; in_t = 8'd128; in_tag = 12'h009;
        @(negedge clk);
        in_t = 8'd0; in_tag = 12'h00A;
        @(negedge clk);
        in_valid9 = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
